// File: rtl/regfile_2w4r_pkg.sv
// Shared definitions for the dual-issue integer register file.
package regfile_2w4r_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NREGS      = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_2w4r_if.sv
// Writeback (two write slots) and decode (four read ports) bundle of the register file.
interface regfile_2w4r_if
   import regfile_2w4r_pkg::*;
#(
   parameter int unsigned XLEN = regfile_2w4r_pkg::XLEN,
   parameter int unsigned AW   = regfile_2w4r_pkg::REG_ADDR_W
);

   logic            we0_i;
   logic [AW-1:0]   waddr0_i;
   logic [XLEN-1:0] wdata0_i;
   logic            we1_i;
   logic [AW-1:0]   waddr1_i;
   logic [XLEN-1:0] wdata1_i;
   logic [AW-1:0]   raddr0a_i;
   logic [AW-1:0]   raddr0b_i;
   logic [AW-1:0]   raddr1a_i;
   logic [AW-1:0]   raddr1b_i;
   logic [XLEN-1:0] rdata0a_o;
   logic [XLEN-1:0] rdata0b_o;
   logic [XLEN-1:0] rdata1a_o;
   logic [XLEN-1:0] rdata1b_o;

   // Pipeline side: writeback and decode drive, decode consumes read data.
   modport master (
      output we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i,
      output raddr0a_i, raddr0b_i, raddr1a_i, raddr1b_i,
      input  rdata0a_o, rdata0b_o, rdata1a_o, rdata1b_o
   );

   // Register file side.
   modport slave (
      input  we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i,
      input  raddr0a_i, raddr0b_i, raddr1a_i, raddr1b_i,
      output rdata0a_o, rdata0b_o, rdata1a_o, rdata1b_o
   );

endinterface

// File: rtl/regfile_2w4r_read_port.sv
// One combinational read port: x0 check, same-cycle write bypass, array fallback.
module regfile_read_port
   import regfile_2w4r_pkg::*;
#(
   parameter int unsigned XLEN   = regfile_2w4r_pkg::XLEN,
   parameter int unsigned AW     = regfile_2w4r_pkg::REG_ADDR_W,
   parameter bit          BYPASS = 1'b1
) (
   input  logic            rst,
   input  logic [AW-1:0]   raddr,
   input  logic [XLEN-1:0] arr_data,
   input  logic            we0,
   input  logic [AW-1:0]   waddr0,
   input  logic [XLEN-1:0] wdata0,
   input  logic            we1,
   input  logic [AW-1:0]   waddr1,
   input  logic [XLEN-1:0] wdata1,
   output logic [XLEN-1:0] rdata
);

   logic hit0;
   logic hit1;

   // Bypass compares sit beside the array read; slot 1 (younger) wins over slot 0.
   always_comb begin
      hit1 = BYPASS && we1 && (waddr1 == raddr);
      hit0 = BYPASS && we0 && (waddr0 == raddr);
      rdata = arr_data;
      if (rst || (raddr == '0)) begin
         rdata = '0;
      end else if (hit1) begin
         rdata = wdata1;
      end else if (hit0) begin
         rdata = wdata0;
      end
   end

endmodule

// File: rtl/regfile_2w4r.sv
// 2-write / 4-read architectural register file; x0 hard-wired to zero.
module regfile_2w4r
   import regfile_2w4r_pkg::*;
#(
   parameter int unsigned XLEN   = regfile_2w4r_pkg::XLEN,
   parameter int unsigned NREGS  = regfile_2w4r_pkg::NREGS,
   parameter bit          BYPASS = 1'b1
) (
   input logic            clk_i,
   input logic            rst_i,
   regfile_2w4r_if.slave  rf
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] regs_q [1:NREGS-1];
   logic [XLEN-1:0] rd_arr [2**AW];

   // Per-register commit; slot 1 is younger so it wins a same-address conflict.
   for (genvar g = 1; g < NREGS; g++) begin : g_reg
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            regs_q[g] <= '0;
         end else if (rf.we1_i && (rf.waddr1_i == AW'(g))) begin
            regs_q[g] <= rf.wdata1_i;
         end else if (rf.we0_i && (rf.waddr0_i == AW'(g))) begin
            regs_q[g] <= rf.wdata0_i;
         end
      end
   end

   // Full-range read view: x0 and any unimplemented addresses read as zero.
   always_comb begin
      for (int i = 0; i < 2**AW; i++) begin
         rd_arr[i] = '0;
      end
      for (int i = 1; i < NREGS; i++) begin
         rd_arr[i] = regs_q[i];
      end
   end

   regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp0a (
      .rst(rst_i), .raddr(rf.raddr0a_i), .arr_data(rd_arr[rf.raddr0a_i]),
      .we0(rf.we0_i), .waddr0(rf.waddr0_i), .wdata0(rf.wdata0_i),
      .we1(rf.we1_i), .waddr1(rf.waddr1_i), .wdata1(rf.wdata1_i),
      .rdata(rf.rdata0a_o)
   );

   regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp0b (
      .rst(rst_i), .raddr(rf.raddr0b_i), .arr_data(rd_arr[rf.raddr0b_i]),
      .we0(rf.we0_i), .waddr0(rf.waddr0_i), .wdata0(rf.wdata0_i),
      .we1(rf.we1_i), .waddr1(rf.waddr1_i), .wdata1(rf.wdata1_i),
      .rdata(rf.rdata0b_o)
   );

   regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp1a (
      .rst(rst_i), .raddr(rf.raddr1a_i), .arr_data(rd_arr[rf.raddr1a_i]),
      .we0(rf.we0_i), .waddr0(rf.waddr0_i), .wdata0(rf.wdata0_i),
      .we1(rf.we1_i), .waddr1(rf.waddr1_i), .wdata1(rf.wdata1_i),
      .rdata(rf.rdata1a_o)
   );

   regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp1b (
      .rst(rst_i), .raddr(rf.raddr1b_i), .arr_data(rd_arr[rf.raddr1b_i]),
      .we0(rf.we0_i), .waddr0(rf.waddr0_i), .wdata0(rf.wdata0_i),
      .we1(rf.we1_i), .waddr1(rf.waddr1_i), .wdata1(rf.wdata1_i),
      .rdata(rf.rdata1b_o)
   );

endmodule

// File: tb/tb_regfile_2w4r.sv
// Bench: one BYPASS=1 and one BYPASS=0 instance driven in lockstep, checked
// against an array model of the architectural registers.
module tb_regfile_2w4r;

   logic        clk;
   logic        rst;
   logic        we0, we1;
   logic [4:0]  wa0, wa1;
   logic [31:0] wd0, wd1;
   logic [4:0]  ra [4];

   logic [31:0] got_b [4];
   logic [31:0] got_n [4];

   logic [31:0] mdl [32];
   int          checks;
   int          errors;

   regfile_2w4r_if if_b ();
   regfile_2w4r_if if_n ();

   assign if_b.we0_i = we0;  assign if_n.we0_i = we0;
   assign if_b.we1_i = we1;  assign if_n.we1_i = we1;
   assign if_b.waddr0_i = wa0;  assign if_n.waddr0_i = wa0;
   assign if_b.waddr1_i = wa1;  assign if_n.waddr1_i = wa1;
   assign if_b.wdata0_i = wd0;  assign if_n.wdata0_i = wd0;
   assign if_b.wdata1_i = wd1;  assign if_n.wdata1_i = wd1;
   assign if_b.raddr0a_i = ra[0];  assign if_n.raddr0a_i = ra[0];
   assign if_b.raddr0b_i = ra[1];  assign if_n.raddr0b_i = ra[1];
   assign if_b.raddr1a_i = ra[2];  assign if_n.raddr1a_i = ra[2];
   assign if_b.raddr1b_i = ra[3];  assign if_n.raddr1b_i = ra[3];

   assign got_b[0] = if_b.rdata0a_o;  assign got_n[0] = if_n.rdata0a_o;
   assign got_b[1] = if_b.rdata0b_o;  assign got_n[1] = if_n.rdata0b_o;
   assign got_b[2] = if_b.rdata1a_o;  assign got_n[2] = if_n.rdata1a_o;
   assign got_b[3] = if_b.rdata1b_o;  assign got_n[3] = if_n.rdata1b_o;

   regfile_2w4r #(.BYPASS(1'b1)) dut_b (.clk_i(clk), .rst_i(rst), .rf(if_b.slave));
   regfile_2w4r #(.BYPASS(1'b0)) dut_n (.clk_i(clk), .rst_i(rst), .rf(if_n.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // What a reader should see this cycle: zero under reset or for x0, otherwise
   // the newest value being written this cycle (if bypassing), else the stored value.
   function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
      logic [31:0] v;
      if (rst || a == 5'd0) return 32'd0;
      v = mdl[a];
      if (byp && we0 && wa0 == a) v = wd0;
      if (byp && we1 && wa1 == a) v = wd1;
      return v;
   endfunction

   // Apply this cycle's writes to the model in program order, then clock the DUTs.
   task automatic tick();
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      end else begin
         if (we0 && wa0 != 5'd0) mdl[wa0] = wd0;
         if (we1 && wa1 != 5'd0) mdl[wa1] = wd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic e1, input logic [4:0] a1, input logic [31:0] d1);
      we0 = e0; wa0 = a0; wd0 = d0;
      we1 = e1; wa1 = a1; wd1 = d1;
   endtask

   task automatic set_r_all(input logic [4:0] a);
      for (int p = 0; p < 4; p++) ra[p] = a;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_w(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      set_r_all(5'd5);
      for (int c = 0; c < 2; c++) begin
         #1;
         for (int p = 0; p < 4; p++) begin
            checks++;
            if (got_b[p] !== 32'd0 || got_n[p] !== 32'd0) begin
               errors++;
               $display("FAIL reset_out port%0d cyc%0d: byp=%h nob=%h want 0",
                        p, c, got_b[p], got_n[p]);
            end
         end
         tick();
      end
      rst = 1'b0;
      set_w(1'b0, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      #1;
      checks++;
      if (got_b[0] !== 32'd0 || got_n[0] !== 32'd0) begin
         errors++;
         $display("FAIL reset_x5 byp=%h nob=%h want 0", got_b[0], got_n[0]);
      end
   endtask

   task automatic test_basic();
      set_w(1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd7, 32'hCAFE_F00D);
      ra[0] = 5'd3; ra[1] = 5'd0; ra[2] = 5'd0; ra[3] = 5'd7;
      #1;
      checks++;
      if (got_b[0] !== 32'h1234_5678 || got_b[3] !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL basic_bypass got %h/%h want 12345678/cafef00d", got_b[0], got_b[3]);
      end
      checks++;
      if (got_n[0] !== 32'd0 || got_n[3] !== 32'd0) begin
         errors++;
         $display("FAIL basic_nobyp_old got %h/%h want 0/0", got_n[0], got_n[3]);
      end
      tick();
      set_w(1'b0, 5'd3, 32'h0, 1'b0, 5'd7, 32'h0);
      #1;
      checks++;
      if (got_n[0] !== 32'h1234_5678 || got_n[3] !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL basic_read got %h/%h want 12345678/cafef00d", got_n[0], got_n[3]);
      end
   endtask

   task automatic test_x0();
      set_w(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
      set_r_all(5'd0);
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (got_b[0] !== 32'd0 || got_n[0] !== 32'd0) begin
            errors++;
            $display("FAIL x0_read cyc%0d byp=%h nob=%h want 0", c, got_b[0], got_n[0]);
         end
         tick();
      end
   endtask

   task automatic test_conflict();
      set_w(1'b1, 5'd9, 32'hAAAA_AAAA, 1'b1, 5'd9, 32'h5555_5555);
      set_r_all(5'd9);
      #1;
      checks++;
      if (got_b[1] !== 32'h5555_5555) begin
         errors++;
         $display("FAIL conflict_bypass got %h want 55555555", got_b[1]);
      end
      tick();
      set_w(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      checks++;
      if (got_b[2] !== 32'h5555_5555 || got_n[2] !== 32'h5555_5555) begin
         errors++;
         $display("FAIL conflict_stored byp=%h nob=%h want 55555555", got_b[2], got_n[2]);
      end
   endtask

   task automatic test_bypass_vs_array();
      set_w(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 32'd0);
      tick();
      set_w(1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 32'd0);
      set_r_all(5'd4);
      #1;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (got_b[p] !== 32'h2 || got_n[p] !== 32'h1) begin
            errors++;
            $display("FAIL bva_same port%0d byp=%h nob=%h want 2/1", p, got_b[p], got_n[p]);
         end
      end
      tick();
      set_w(1'b0, 5'd4, 32'h9, 1'b0, 5'd0, 32'd0);
      #1;
      checks++;
      if (got_n[0] !== 32'h2 || got_b[3] !== 32'h2) begin
         errors++;
         $display("FAIL bva_next nob=%h byp=%h want 2", got_n[0], got_b[3]);
      end
   endtask

   task automatic test_reset_midstream();
      set_w(1'b1, 5'd10, 32'h0BAD_BEEF, 1'b0, 5'd0, 32'd0);
      tick();
      rst = 1'b1;
      set_w(1'b1, 5'd10, 32'h1111_2222, 1'b1, 5'd11, 32'h3333_4444);
      tick();
      rst = 1'b0;
      set_w(1'b0, 5'd10, 32'd0, 1'b0, 5'd11, 32'd0);
      ra[0] = 5'd10; ra[1] = 5'd11; ra[2] = 5'd3; ra[3] = 5'd9;
      #1;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (got_n[p] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset port%0d got %h want 0", p, got_n[p]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 39) == 0);
         set_w(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) wa1 = wa0;
         for (int p = 0; p < 4; p++) begin
            case ($urandom_range(0, 3))
               0: ra[p] = wa0;
               1: ra[p] = wa1;
               default: ra[p] = 5'($urandom);
            endcase
         end
         #1;
         for (int p = 0; p < 4; p++) begin
            checks++;
            if (got_b[p] !== expect_rd(ra[p], 1'b1) || got_n[p] !== expect_rd(ra[p], 1'b0)) begin
               errors++;
               $display("FAIL random c%0d port%0d ra=%0d byp=%h/%h nob=%h/%h", c, p, ra[p],
                        got_b[p], expect_rd(ra[p], 1'b1), got_n[p], expect_rd(ra[p], 1'b0));
            end
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      rst = 1'b1;
      set_w(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      set_r_all(5'd0);
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_x0();
      test_conflict();
      test_bypass_vs_array();
      test_reset_midstream();
      // Bring the model in line with the array before random traffic.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
